onehot_scan_decoder: RTL

//   Parametrised N-to-2^N one-hot decoder with registered outputs and enable.
//   Two modes:
//   - DIRECT: decodes a loaded select value.
//   - SCAN: an internal counter walks every output in turn, holding each one
//     for a programmable dwell time.

---
 rtl/onehot_scan_decoder.sv | 90 +++++++++
 1 files changed

// File: rtl/onehot_scan_decoder.sv
// One-hot decoder with a DIRECT (loaded select) mode and a SCAN (dwell-timed walk) mode.
// All outputs are registered with 1-cycle latency; there is no backpressure.
module onehot_scan_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    load,
    input  logic [SEL_W-1:0]        a,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    busy,
    output logic                    wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam logic [OUT_W-1:0] ONE_HOT_0 = OUT_W'(1);
    localparam logic [SEL_W-1:0] IDX_LAST  = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else if (mode) begin
            if (state_q != SCAN) begin
                state_d = SCAN;
                idx_d   = '0;
                cnt_d   = '0;
            end else if (cnt_q == dwell) begin
                cnt_d  = '0;
                idx_d  = idx_q + SEL_W'(1);
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                // A dwell lowered below the count is reached again after the counter rolls over.
                cnt_d = cnt_q + DWELL_W'(1);
            end
        end else if (load) begin
            state_d = DIRECT;
            idx_d   = a;
        end else if (state_q == SCAN) begin
            state_d = DIRECT;
        end
        y_d    = (state_d == IDLE) ? '0 : (ONE_HOT_0 << idx_d);
        busy_d = (state_d == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule
